cla_addsub_pipe: RTL and testbench
==================================

CLA_ADDSUB_PIPE -- requirements
Module: cla_addsub_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 12: operand/result width in bits, legal range 4..32.
REQ-002 SHALL have parameter GROUP, default 4: carry-lookahead group width in bits, legal range 2..8.
REQ-003 SHALL derive localparam STAGES = ceil(WIDTH/GROUP); the last group is WIDTH - (STAGES-1)*GROUP bits wide.
REQ-004 SHALL use one clock and a synchronous, active-high reset; all ports are listed below, clock and reset first.
REQ-005 CLK  input  1  rising-edge clock for all state.
REQ-006 RST  input  1  synchronous active-high reset.
REQ-007 IN_VALID  input  1  operand beat present.
REQ-008 IN_READY  output  1  block accepts a beat this cycle.
REQ-009 A  input  WIDTH  operand A, two's complement.
REQ-010 B  input  WIDTH  operand B, two's complement.
REQ-011 CIN  input  1  carry-in, used only when SUB=0.
REQ-012 SUB  input  1  0 = A+B+CIN; 1 = A-B.
REQ-013 OUT_VALID  output  1  result beat present.
REQ-014 OUT_READY  input  1  downstream accepts the result.
REQ-015 SUM  output  WIDTH  result bits.
REQ-016 COUT  output  1  carry out of MSB; for SUB=1, 1 means no borrow.
REQ-017 OVF  output  1  signed overflow.
REQ-018 ZERO  output  1  SUM equals 0.
REQ-019 P_OUT  output  WIDTH  propagate vector (A ^ B_eff) of the result beat.

Function
REQ-020 B_eff SHALL be B when SUB=0 and ~B when SUB=1; carry-in SHALL be CIN when SUB=0 and 1 when SUB=1.
REQ-021 A beat SHALL be accepted on any cycle with IN_VALID && IN_READY.
REQ-022 The pipeline SHALL have STAGES register stages; stage k resolves group k with 4-style lookahead (per-bit P/G, parallel carry equations within the group) using the carry registered from stage k-1.
REQ-023 Unresolved upper operand groups and resolved lower sum groups SHALL be carried forward in stage registers alongside a per-stage valid bit.
REQ-024 Latency SHALL be exactly STAGES cycles from acceptance to OUT_VALID when never stalled (3 cycles at defaults).
REQ-025 Stall SHALL be global: stall = OUT_VALID && !OUT_READY; when stalled, no stage register changes.
REQ-026 IN_READY SHALL equal !stall, combinationally.
REQ-027 Throughput SHALL be one beat per cycle when OUT_READY stays high; beats SHALL exit in acceptance order with none lost or duplicated.
REQ-028 Stage valid bits SHALL advance only when not stalled; bubbles (IN_VALID=0) SHALL propagate as invalid stages.
REQ-029 OVF SHALL equal carry into MSB XOR carry out of MSB, from the final group.
REQ-030 ZERO SHALL be computed from the final registered SUM; P_OUT SHALL be the accepted beat's full propagate vector, delayed with it.
REQ-031 SUM, COUT, OVF, ZERO and P_OUT SHALL hold stable while OUT_VALID=1 and OUT_READY=0.
REQ-032 When OUT_VALID=0 the data outputs SHALL hold their last values; they carry no meaning.
REQ-033 WIDTH not a multiple of GROUP SHALL be handled by the narrower last group; COUT/OVF SHALL come from bit WIDTH-1.

Reset
REQ-034 With RST=1 at a rising edge, all stage valid bits, OUT_VALID, SUM, COUT, OVF, ZERO and P_OUT SHALL become 0.
REQ-035 Reset mid-operation SHALL discard all in-flight beats; no beat accepted before reset SHALL appear afterwards.
REQ-036 IN_READY SHALL be 1 in the first cycle after reset release.

Verification
REQ-037 Add: A=0x005, B=0x003, CIN=0, SUB=0 -> 3 cycles later SUM=0x008, COUT=0, OVF=0, ZERO=0.
REQ-038 Overflow: A=0x7FF, B=0x001, SUB=0 -> SUM=0x800, OVF=1, COUT=0; A=0x800, B=0x800 -> SUM=0x000, COUT=1, OVF=1, ZERO=1.
REQ-039 Subtract: A=0x000, B=0x001, SUB=1 -> SUM=0xFFF, COUT=0, OVF=0; A=0x005, B=0x005, SUB=1 -> SUM=0x000, COUT=1, ZERO=1.
REQ-040 Backpressure: stream 6 beats A=1..6, B=0x010, OUT_READY low for 2 cycles mid-stream -> IN_READY low during the stall, outputs 0x011..0x016 in order, held while stalled.
REQ-041 Reset mid-flight: accept 2 beats, assert RST one cycle before the first would exit -> OUT_VALID stays 0 and the beats never appear.
REQ-042 Parameter sweep: WIDTH=10, GROUP=4 (STAGES=3) and WIDTH=8, GROUP=2 (STAGES=4), 10k random beats each -> every result matches a reference model, latency = STAGES.

Source files
------------

// File: rtl/cla_addsub_pipe.sv
// -----------------------------------------------------------------------------
// cla_addsub_pipe
//   Pipelined carry-lookahead adder/subtractor. The operands are split into
//   GROUP-bit groups. Pipeline stage k resolves group k with parallel
//   lookahead equations, using the carry registered by stage k-1. Operand bits
//   that are not yet resolved travel forward alongside the sum bits that are
//   already resolved. A single global stall freezes every stage while a result
//   waits for downstream.
//
// Ports
//   CLK        rising-edge clock
//   RST        synchronous active-high reset
//   IN_VALID   operand beat present
//   IN_READY   a beat is accepted this cycle (equals !stall)
//   A, B       WIDTH-bit two's complement operands
//   CIN        carry-in, used only when SUB=0
//   SUB        0: A+B+CIN   1: A-B
//   OUT_VALID  result beat present
//   OUT_READY  downstream accepts the result
//   SUM        result bits
//   COUT       carry out of bit WIDTH-1 (for SUB=1, 1 means no borrow)
//   OVF        signed overflow
//   ZERO       SUM == 0
//   P_OUT      propagate vector A ^ B_eff of the result beat
// -----------------------------------------------------------------------------
module cla_addsub_pipe #(
  parameter int WIDTH = 12,
  parameter int GROUP = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CIN,
  input  logic             SUB,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] SUM,
  output logic             COUT,
  output logic             OVF,
  output logic             ZERO,
  output logic [WIDTH-1:0] P_OUT
);

  localparam int STAGES = (WIDTH + GROUP - 1) / GROUP;
  localparam int LAST   = STAGES - 1;
  // Operand registers are only needed ahead of the final stage.
  localparam int OPS    = (STAGES > 1) ? STAGES - 1 : 1;
  localparam int IDXW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  // Per-stage pipeline state. The last stage doubles as the output register.
  logic [STAGES-1:0][WIDTH-1:0] st_s;   // resolved sum bits
  logic [STAGES-1:0][WIDTH-1:0] st_p;   // full propagate vector of the beat
  logic [STAGES-1:0]            st_c;   // carry out of the group just resolved
  logic [STAGES-1:0]            st_v;   // stage holds a valid beat
  logic [OPS-1:0][WIDTH-1:0]    op_a;   // operand A still to be resolved
  logic [OPS-1:0][WIDTH-1:0]    op_b;   // effective operand B still to be resolved
  logic                         ovf_q;
  logic                         zero_q;

  // Next-state values for every stage.
  logic [STAGES-1:0][WIDTH-1:0] nxt_s;
  logic [STAGES-1:0][WIDTH-1:0] nxt_p;
  logic [STAGES-1:0]            nxt_c;
  logic [STAGES-1:0]            nxt_v;
  logic [OPS-1:0][WIDTH-1:0]    nxt_a;
  logic [OPS-1:0][WIDTH-1:0]    nxt_b;
  logic                         msb_c;  // carry into bit WIDTH-1

  // Working values for the stage currently being evaluated.
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic [WIDTH-1:0] src_s;
  logic [WIDTH-1:0] src_p;
  logic             src_c;
  logic             src_v;
  logic [GROUP-1:0] gp;
  logic [GROUP-1:0] gg;
  logic [GROUP:0]   carry;
  logic             cy;
  logic             term;
  logic [IDXW-1:0]  bsel;
  int               bi;
  int               kp;
  int               kk;

  logic stall;

  assign stall    = st_v[LAST] & ~OUT_READY;
  assign IN_READY = ~stall;

  // NOTE: every variable written here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    nxt_s = '0;
    nxt_p = '0;
    nxt_c = '0;
    nxt_v = '0;
    nxt_a = '0;
    nxt_b = '0;
    msb_c = 1'b0;
    src_a = '0;
    src_b = '0;
    src_s = '0;
    src_p = '0;
    src_c = 1'b0;
    src_v = 1'b0;
    gp    = '0;
    gg    = '0;
    carry = '0;
    cy    = 1'b0;
    term  = 1'b0;
    bsel  = '0;
    bi    = 0;
    kp    = 0;
    kk    = 0;

    for (int k = 0; k < STAGES; k++) begin
      kp = (k > 0) ? k - 1 : 0;
      if (k == 0) begin
        // Subtraction is A + ~B + 1.
        src_a = A;
        src_b = SUB ? ~B : B;
        src_c = SUB | CIN;
        src_v = IN_VALID;
        src_s = '0;
        src_p = A ^ (SUB ? ~B : B);
      end else begin
        src_a = op_a[kp];
        src_b = op_b[kp];
        src_c = st_c[kp];
        src_v = st_v[kp];
        src_s = st_s[kp];
        src_p = st_p[kp];
      end

      // Per-bit propagate/generate. Bit positions past the MSB (narrow last
      // group) propagate without generating, so the group carry-out equals
      // the carry out of bit WIDTH-1.
      for (int i = 0; i < GROUP; i++) begin
        bi   = k * GROUP + i;
        bsel = IDXW'((bi < WIDTH) ? bi : WIDTH - 1);
        if (bi < WIDTH) begin
          gp[i] = src_a[bsel] ^ src_b[bsel];
          gg[i] = src_a[bsel] & src_b[bsel];
        end else begin
          gp[i] = 1'b1;
          gg[i] = 1'b0;
        end
      end

      // Parallel lookahead: c[i] = c0 & p[0..i-1] | OR_j g[j] & p[j+1..i-1].
      for (int i = 0; i <= GROUP; i++) begin
        cy = src_c;
        for (int j = 0; j < i; j++) cy = cy & gp[j];
        for (int j = 0; j < i; j++) begin
          term = gg[j];
          for (int m = j + 1; m < i; m++) term = term & gp[m];
          cy = cy | term;
        end
        carry[i] = cy;
      end

      for (int i = 0; i < GROUP; i++) begin
        bi   = k * GROUP + i;
        bsel = IDXW'((bi < WIDTH) ? bi : WIDTH - 1);
        if (bi < WIDTH) begin
          src_s[bsel] = gp[i] ^ carry[i];
          if (bi == WIDTH - 1) msb_c = carry[i];
        end
      end

      nxt_s[k] = src_s;
      nxt_p[k] = src_p;
      nxt_c[k] = carry[GROUP];
      nxt_v[k] = src_v;
      if (k < LAST) begin
        kk        = (k < OPS) ? k : OPS - 1;
        nxt_a[kk] = src_a;
        nxt_b[kk] = src_b;
      end
    end
  end

  // NOTE: pipeline state uses non-blocking assignments so every stage samples
  // the pre-edge value of the stage before it.
  always_ff @(posedge CLK) begin
    if (RST) begin
      // NOTE: the whole pipeline, data included, is cleared; the outputs must
      // read 0 after reset and in-flight beats must never reappear.
      st_s   <= '0;
      st_p   <= '0;
      st_c   <= '0;
      st_v   <= '0;
      op_a   <= '0;
      op_b   <= '0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else if (!stall) begin
      st_v <= nxt_v;
      op_a <= nxt_a;
      op_b <= nxt_b;
      for (int k = 0; k < LAST; k++) begin
        st_s[k] <= nxt_s[k];
        st_p[k] <= nxt_p[k];
        st_c[k] <= nxt_c[k];
      end
      // Output data only changes when a real beat lands, so it holds its last
      // value across bubbles.
      if (nxt_v[LAST]) begin
        st_s[LAST] <= nxt_s[LAST];
        st_p[LAST] <= nxt_p[LAST];
        st_c[LAST] <= nxt_c[LAST];
        ovf_q      <= msb_c ^ nxt_c[LAST];
        zero_q     <= (nxt_s[LAST] == '0);
      end
    end
  end

  assign OUT_VALID = st_v[LAST];
  assign SUM       = st_s[LAST];
  assign COUT      = st_c[LAST];
  assign OVF       = ovf_q;
  assign ZERO      = zero_q;
  assign P_OUT     = st_p[LAST];

endmodule

// File: tb/tb_cla_addsub_pipe.sv
// -----------------------------------------------------------------------------
// tb_cla_addsub_pipe
//   Self-checking bench for cla_addsub_pipe. Three instances share stimulus:
//   the default 12/4 build (with backpressure) and 10/4 and 8/2 builds that are
//   always ready. Expected results are queued on acceptance and compared when
//   each instance presents a result.
// -----------------------------------------------------------------------------
module tb_cla_addsub_pipe;

  typedef struct {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
    logic [31:0] p;
    int          cyc;
    logic        lat;
  } exp_t;

  typedef struct {
    logic [11:0] a;
    logic [11:0] b;
    logic        cin;
    logic        sub;
    logic [11:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
    logic [11:0] p;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        cin = 1'b0;
  logic        sub = 1'b0;
  logic        ordy = 1'b1;
  logic [11:0] a_in = '0;
  logic [11:0] b_in = '0;

  logic        rdy0, ov0, cout0, ovf0, zero0;
  logic [11:0] sum0, p0;
  logic        rdy1, ov1, cout1, ovf1, zero1;
  logic [9:0]  sum1, p1;
  logic        rdy2, ov2, cout2, ovf2, zero2;
  logic [7:0]  sum2, p2;

  always #5 clk = ~clk;

  cla_addsub_pipe #(.WIDTH(12), .GROUP(4)) dut (
    .CLK(clk), .RST(rst), .IN_VALID(in_valid), .IN_READY(rdy0),
    .A(a_in), .B(b_in), .CIN(cin), .SUB(sub),
    .OUT_VALID(ov0), .OUT_READY(ordy), .SUM(sum0), .COUT(cout0),
    .OVF(ovf0), .ZERO(zero0), .P_OUT(p0)
  );

  cla_addsub_pipe #(.WIDTH(10), .GROUP(4)) dut10 (
    .CLK(clk), .RST(rst), .IN_VALID(in_valid), .IN_READY(rdy1),
    .A(a_in[9:0]), .B(b_in[9:0]), .CIN(cin), .SUB(sub),
    .OUT_VALID(ov1), .OUT_READY(1'b1), .SUM(sum1), .COUT(cout1),
    .OVF(ovf1), .ZERO(zero1), .P_OUT(p1)
  );

  cla_addsub_pipe #(.WIDTH(8), .GROUP(2)) dut8 (
    .CLK(clk), .RST(rst), .IN_VALID(in_valid), .IN_READY(rdy2),
    .A(a_in[7:0]), .B(b_in[7:0]), .CIN(cin), .SUB(sub),
    .OUT_VALID(ov2), .OUT_READY(1'b1), .SUM(sum2), .COUT(cout2),
    .OVF(ovf2), .ZERO(zero2), .P_OUT(p2)
  );

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];
  logic use_ovr = 1'b0;
  logic lat_main = 1'b0;
  exp_t ovr;
  logic last_acc0 = 1'b0;
  logic last_acc1 = 1'b0;
  vec_t tbl[10];

  task automatic check(input string name, input logic ok, input string detail);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: %s", name, detail);
    end
  endtask

  // Plain integer reference: w-bit add of A, B_eff and the carry-in.
  function automatic exp_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                 input logic ci, input logic sb);
    exp_t        e;
    logic [63:0] mask, aa, bb, full, px;
    mask   = (64'd1 << w) - 64'd1;
    aa     = {32'd0, a} & mask;
    bb     = (sb ? ~{32'd0, b} : {32'd0, b}) & mask;
    full   = aa + bb + {63'd0, sb | ci};
    px     = aa ^ bb;
    e.sum  = full[31:0] & mask[31:0];
    e.cout = full[w];
    e.ovf  = (aa[w-1] == bb[w-1]) && (full[w-1] != aa[w-1]);
    e.zero = (e.sum == 32'd0);
    e.p    = px[31:0];
    e.cyc  = 0;
    e.lat  = 1'b0;
    return e;
  endfunction

  task automatic score(input int d, input int stages, input logic [31:0] s, input logic co,
                       input logic ov, input logic z, input logic [31:0] p, input logic pop);
    exp_t e;
    int   n;
    n = (d == 0) ? q0.size() : (d == 1) ? q1.size() : q2.size();
    if (n == 0) begin
      check($sformatf("dut%0d_unexpected", d), 1'b0,
            $sformatf("got sum=%h while no beat is outstanding", s));
      return;
    end
    case (d)
      0:       e = q0[0];
      1:       e = q1[0];
      default: e = q2[0];
    endcase
    if (pop) begin
      case (d)
        0:       void'(q0.pop_front());
        1:       void'(q1.pop_front());
        default: void'(q2.pop_front());
      endcase
    end
    check($sformatf("dut%0d_%s", d, pop ? "result" : "hold"),
          s == e.sum && co == e.cout && ov == e.ovf && z == e.zero && p == e.p,
          $sformatf("got sum=%h cout=%b ovf=%b zero=%b p=%h, want sum=%h cout=%b ovf=%b zero=%b p=%h",
                    s, co, ov, z, p, e.sum, e.cout, e.ovf, e.zero, e.p));
    if (pop && e.lat)
      check($sformatf("dut%0d_latency", d), (cyc - e.cyc) == stages,
            $sformatf("got %0d cycles, want %0d", cyc - e.cyc, stages));
  endtask

  // One clock cycle: drive on the falling edge, observe 1 time unit later,
  // account for what the next rising edge will transfer.
  task automatic step(input logic v, input logic [11:0] a, input logic [11:0] b,
                      input logic ci, input logic sb, input logic rdy, input logic rs);
    exp_t e;
    @(negedge clk);
    in_valid = v;
    a_in     = a;
    b_in     = b;
    cin      = ci;
    sub      = sb;
    ordy     = rdy;
    rst      = rs;
    #1;
    last_acc0 = 1'b0;
    last_acc1 = 1'b0;
    if (rs) begin
      q0.delete();
      q1.delete();
      q2.delete();
    end else begin
      if (ov0) begin
        if (rdy) begin
          score(0, 3, {20'd0, sum0}, cout0, ovf0, zero0, {20'd0, p0}, 1'b1);
        end else begin
          check("in_ready_stall", rdy0 == 1'b0, $sformatf("got IN_READY=%b, want 0", rdy0));
          score(0, 3, {20'd0, sum0}, cout0, ovf0, zero0, {20'd0, p0}, 1'b0);
        end
      end
      if (ov1) score(1, 3, {22'd0, sum1}, cout1, ovf1, zero1, {22'd0, p1}, 1'b1);
      if (ov2) score(2, 4, {24'd0, sum2}, cout2, ovf2, zero2, {24'd0, p2}, 1'b1);
      if (v && rdy0) begin
        e     = use_ovr ? ovr : model(12, {20'd0, a}, {20'd0, b}, ci, sb);
        e.cyc = cyc;
        e.lat = lat_main;
        q0.push_back(e);
        last_acc0 = 1'b1;
      end
      if (v && rdy1) begin
        e     = model(10, {20'd0, a}, {20'd0, b}, ci, sb);
        e.cyc = cyc;
        e.lat = 1'b1;
        q1.push_back(e);
        last_acc1 = 1'b1;
      end
      if (v && rdy2) begin
        e     = model(8, {20'd0, a}, {20'd0, b}, ci, sb);
        e.cyc = cyc;
        e.lat = 1'b1;
        q2.push_back(e);
      end
    end
    cyc++;
  endtask

  task automatic drain();
    for (int n = 0; n < 40 && (q0.size() + q1.size() + q2.size()) > 0; n++)
      step(1'b0, 12'h000, 12'h000, 1'b0, 1'b0, 1'b1, 1'b0);
    check("drain", (q0.size() + q1.size() + q2.size()) == 0,
          $sformatf("got %0d/%0d/%0d beats outstanding, want none", q0.size(), q1.size(), q2.size()));
  endtask

  initial begin
    int          idx;
    int          cnt;
    logic        rv;
    logic [11:0] ra, rb;

    //            a       b       cin   sub   sum     cout  ovf   zero  p
    tbl[0] = '{12'h005, 12'h003, 1'b0, 1'b0, 12'h008, 1'b0, 1'b0, 1'b0, 12'h006};
    tbl[1] = '{12'h7FF, 12'h001, 1'b0, 1'b0, 12'h800, 1'b0, 1'b1, 1'b0, 12'h7FE};
    tbl[2] = '{12'h800, 12'h800, 1'b0, 1'b0, 12'h000, 1'b1, 1'b1, 1'b1, 12'h000};
    tbl[3] = '{12'h000, 12'h001, 1'b0, 1'b1, 12'hFFF, 1'b0, 1'b0, 1'b0, 12'hFFE};
    tbl[4] = '{12'h005, 12'h005, 1'b0, 1'b1, 12'h000, 1'b1, 1'b0, 1'b1, 12'hFFF};
    tbl[5] = '{12'hFFF, 12'h001, 1'b0, 1'b0, 12'h000, 1'b1, 1'b0, 1'b1, 12'hFFE};
    tbl[6] = '{12'h0FF, 12'h001, 1'b1, 1'b0, 12'h101, 1'b0, 1'b0, 1'b0, 12'h0FE};
    tbl[7] = '{12'h800, 12'h001, 1'b0, 1'b1, 12'h7FF, 1'b1, 1'b1, 1'b0, 12'h7FE};
    tbl[8] = '{12'h123, 12'h456, 1'b1, 1'b1, 12'hCCD, 1'b0, 1'b0, 1'b0, 12'hA8A};
    tbl[9] = '{12'h7FF, 12'h7FF, 1'b1, 1'b0, 12'hFFF, 1'b0, 1'b1, 1'b0, 12'h000};

    // Reset state.
    step(1'b0, 12'h000, 12'h000, 1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b0, 12'h000, 12'h000, 1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b0, 12'h000, 12'h000, 1'b0, 1'b0, 1'b1, 1'b0);
    check("reset_out_valid", ov0 == 1'b0, $sformatf("got %b, want 0", ov0));
    check("reset_sum", sum0 == 12'h000, $sformatf("got %h, want 000", sum0));
    check("reset_flags", {cout0, ovf0, zero0} == 3'b000,
          $sformatf("got cout/ovf/zero=%b%b%b, want 000", cout0, ovf0, zero0));
    check("reset_p", p0 == 12'h000, $sformatf("got %h, want 000", p0));
    check("reset_in_ready", rdy0 == 1'b1, $sformatf("got %b, want 1", rdy0));

    // Directed vectors, back to back, main instance checked against the table.
    use_ovr  = 1'b1;
    lat_main = 1'b1;
    for (int i = 0; i < 10; i++) begin
      ovr.sum  = {20'd0, tbl[i].sum};
      ovr.cout = tbl[i].cout;
      ovr.ovf  = tbl[i].ovf;
      ovr.zero = tbl[i].zero;
      ovr.p    = {20'd0, tbl[i].p};
      step(1'b1, tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub, 1'b1, 1'b0);
    end
    use_ovr = 1'b0;
    drain();
    lat_main = 1'b0;

    // Backpressure: six beats, OUT_READY low for two cycles mid-stream.
    idx = 1;
    for (int t = 0; t < 20; t++) begin
      step(idx <= 6, 12'(idx), 12'h010, 1'b0, 1'b0, !(t == 4 || t == 5), 1'b0);
      if (last_acc0) idx++;
    end
    check("bp_all_accepted", idx == 7, $sformatf("got %0d beats accepted, want 6", idx - 1));
    drain();

    // Reset while two beats are in flight, one cycle before the first exits.
    step(1'b1, 12'h0AA, 12'h001, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 12'h0BB, 12'h001, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 12'h000, 12'h000, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int t = 0; t < 6; t++) begin
      step(1'b0, 12'h000, 12'h000, 1'b0, 1'b0, 1'b1, 1'b0);
      if (t == 0)
        check("rst_flight_in_ready", rdy0 == 1'b1, $sformatf("got %b, want 1", rdy0));
      check("rst_flight_out_valid", {ov0, ov1, ov2} == 3'b000,
            $sformatf("got OUT_VALID=%b%b%b, want 000", ov0, ov1, ov2));
    end

    // Random traffic: bubbles everywhere, random backpressure on the main
    // instance, 10k beats through the always-ready instances.
    cnt = 0;
    for (int t = 0; t < 14000 && cnt < 10000; t++) begin
      rv = ($urandom_range(0, 7) != 0);
      ra = 12'($urandom);
      rb = 12'($urandom);
      step(rv, ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           $urandom_range(0, 3) != 0, 1'b0);
      if (last_acc1) cnt++;
    end
    check("random_beats", cnt == 10000, $sformatf("got %0d beats, want 10000", cnt));
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
